// File: rtl/ps2_transmitter_if.sv
// Command-side handshake of the PS/2 host transmitter: start strobe, byte and status ticks.
`timescale 1ns/1ps
interface ps2_transmitter_if;
   logic       wr_ps2;
   logic [7:0] din;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       tx_err_tick;

   modport master (
      output wr_ps2, din,
      input  tx_idle, tx_done_tick, tx_err_tick
   );

   modport slave (
      input  wr_ps2, din,
      output tx_idle, tx_done_tick, tx_err_tick
   );
endinterface

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the device, ACK check.
// Lines are only ever pulled low through the two open-drain enables.
`timescale 1ns/1ps
module ps2_transmitter #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic               clk,
   input  logic               reset,
   ps2_transmitter_if.slave   cmd,
   input  logic               PS2clk,
   input  logic               key_data,
   output logic               ps2c_oe,
   output logic               ps2d_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RTS, START, DATA, ACK, WAIT_REL} state_t;

   state_t                 state;
   logic [1:0]             clk_sync;
   logic [1:0]             data_sync;
   logic [FILTER_LEN-1:0]  filter_reg;
   logic                   filt_level;
   logic                   filt_prev;
   logic                   fall_tick;
   logic                   data_s;
   logic [9:0]             frame;
   logic [3:0]             bit_cnt;
   logic [INH_W-1:0]       inh_cnt;
   logic [TO_W-1:0]        to_cnt;
   logic                   ack_ok;
   logic                   timing_out;

   // The filtered clock level only flips once the whole window agrees, rejecting line glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         filter_reg <= '1;
         filt_level <= 1'b1;
         filt_prev  <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[0], PS2clk};
         data_sync  <= {data_sync[0], key_data};
         filter_reg <= {filter_reg[FILTER_LEN-2:0], clk_sync[1]};
         if (&filter_reg)
            filt_level <= 1'b1;
         else if (~|filter_reg)
            filt_level <= 1'b0;
         filt_prev  <= filt_level;
      end
   end

   assign fall_tick  = filt_prev & ~filt_level;
   assign data_s     = data_sync[1];
   assign timing_out = (state == START || state == DATA || state == ACK) && (to_cnt == TO_LAST);

   // A device that stops clocking mid-frame is abandoned; the timeout outranks any edge that cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         ps2c_oe          <= 1'b0;
         ps2d_oe          <= 1'b0;
         cmd.tx_idle      <= 1'b1;
         cmd.tx_done_tick <= 1'b0;
         cmd.tx_err_tick  <= 1'b0;
         frame            <= '0;
         bit_cnt          <= '0;
         inh_cnt          <= '0;
         to_cnt           <= '0;
         ack_ok           <= 1'b0;
      end else begin
         cmd.tx_done_tick <= 1'b0;
         cmd.tx_err_tick  <= 1'b0;
         if (timing_out) begin
            cmd.tx_err_tick <= 1'b1;
            ps2c_oe         <= 1'b0;
            ps2d_oe         <= 1'b0;
            cmd.tx_idle     <= 1'b1;
            state           <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd.wr_ps2) begin
                     frame       <= {1'b1, ~^cmd.din, cmd.din};
                     inh_cnt     <= '0;
                     ps2c_oe     <= 1'b1;
                     cmd.tx_idle <= 1'b0;
                     state       <= RTS;
                  end
               end
               RTS: begin
                  if (inh_cnt == INH_LAST) begin
                     ps2c_oe <= 1'b0;
                     ps2d_oe <= 1'b1;
                     bit_cnt <= '0;
                     to_cnt  <= '0;
                     state   <= START;
                  end else begin
                     inh_cnt <= inh_cnt + 1'b1;
                  end
               end
               START: begin
                  to_cnt <= to_cnt + 1'b1;
                  if (fall_tick) begin
                     ps2d_oe <= ~frame[0];
                     frame   <= {1'b0, frame[9:1]};
                     state   <= DATA;
                  end
               end
               DATA: begin
                  to_cnt <= to_cnt + 1'b1;
                  if (fall_tick) begin
                     if (bit_cnt == 4'd9) begin
                        ack_ok <= ~data_s;
                        state  <= ACK;
                     end else begin
                        ps2d_oe <= ~frame[0];
                        frame   <= {1'b0, frame[9:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               ACK: begin
                  to_cnt <= to_cnt + 1'b1;
                  ps2d_oe <= 1'b0;
                  if (!ack_ok)
                     cmd.tx_err_tick <= 1'b1;
                  state <= WAIT_REL;
               end
               WAIT_REL: begin
                  ps2c_oe <= 1'b0;
                  ps2d_oe <= 1'b0;
                  if (filt_level && data_s) begin
                     cmd.tx_done_tick <= ack_ok;
                     cmd.tx_idle      <= 1'b1;
                     state            <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
